// File: rtl/inst_package.sv
// Shared types and constants for the subcore data-memory path.
// Request channels, tag-pipeline entries and memory sizing used by the arbiter.
package inst_package;

    localparam int SUBCORE_NUM    = 4;
    localparam int DATA_MEM_DEPTH = 131072;
    localparam int MEM_RD_LAT     = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic        we;
    } data_in;

    typedef struct packed {
        logic       valid;
        logic [2:0] port;
        logic       err;
    } mem_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
// The pointer register lives in the parent so this stays purely combinational.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx
);

    logic found;

    // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Scan by rotational distance from ptr; the first hit is the winner.
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && req[j] &&
                    ((j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_PORTS - int'(ptr))) == i) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter from NUM_PORTS subcore load/store channels onto one shared
// single-port data memory; read data is routed back through a tagged pipeline.
module data_mem_arbiter
    import inst_package::*;
#(
    parameter int NUM_PORTS = SUBCORE_NUM,
    parameter int DEPTH     = DATA_MEM_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int RD_LAT    = MEM_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] req_ready,
    input  data_in               req [NUM_PORTS],
    output logic [NUM_PORTS-1:0] rsp_valid,
    output logic [NUM_PORTS-1:0] rsp_err,
    output logic [31:0]          rsp_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_PORTS-1:0] gnt;
    data_in               sel;
    logic                 accept;
    logic                 in_range;
    mem_tag_t             tag_q [RD_LAT+1];
    mem_tag_t             rsp_tag;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_rr_arbiter (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(gnt),
        .idx  (gnt_idx)
    );

    assign req_ready = rstn ? gnt : '0;
    assign accept    = |req_ready;
    assign sel       = req[gnt_idx];
    assign in_range  = sel.addr < 32'(DEPTH);
    assign rsp_tag   = tag_q[RD_LAT];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_data  <= '0;
            // NOTE: the tag stages are flops, not RAM, so clearing them drops in-flight reads.
            for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            mem_en <= accept & in_range;
            mem_we <= accept & in_range & sel.we;
            if (accept) begin
                rr_ptr   <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                mem_addr <= sel.addr[ADDR_W-1:0];
                mem_din  <= sel.din;
            end

            // Out-of-range reads still ride the pipeline so the error lands with read timing.
            tag_q[0] <= '{valid: accept & ~sel.we, port: 3'(gnt_idx), err: ~in_range};
            for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];

            rsp_valid <= '0;
            rsp_err   <= '0;
            if (rsp_tag.valid) begin
                rsp_data <= rsp_tag.err ? '0 : mem_dout;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (rsp_tag.port == 3'(p)) begin
                        rsp_valid[p] <= 1'b1;
                        rsp_err[p]   <= rsp_tag.err;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-level model:
// grant order by rotating priority, memory contents in an array, responses scheduled by cycle.
module tb_data_mem_arbiter;
    import inst_package::*;

    localparam int N     = SUBCORE_NUM;
    localparam int DEPTH = DATA_MEM_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int RDL   = MEM_RD_LAT;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    data_in        req [N];
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_err;
    logic [31:0]   rsp_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req      (req),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_data (rsp_data),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural BRAM with RDL cycles of read latency; preloaded with a hash of the address.
    logic [31:0] bram [int];
    logic [31:0] rd_pipe [RDL];
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[int'(mem_addr)] = mem_din;
        rd_pipe[0] <= bram.exists(int'(mem_addr)) ? bram[int'(mem_addr)] : init_val(int'(mem_addr));
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RDL-1];

    // Reference model state
    logic [31:0]  model_mem [int];
    logic [N-1:0] exp_rv [int];
    logic [N-1:0] exp_re [int];
    logic [31:0]  exp_rd [int];
    logic         exp_mwe [int];
    logic [AW-1:0] exp_maddr [int];
    logic [31:0]  exp_mdin [int];
    int           rr_m;
    int           cyc;
    bit           rst_seen;
    int           last_grant;
    int           vectors;
    int           miscompares;
    logic [N-1:0] cur_v;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic data_in mk(input logic [31:0] a, input logic [31:0] d, input logic w);
        data_in r;
        r.addr = a;
        r.din  = d;
        r.we   = w;
        return r;
    endfunction

    function automatic data_in rand_req();
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 19);
        if (sel < 16)       a = 32'($urandom_range(0, 15));
        else if (sel == 16) a = 32'(DEPTH - 1);
        else if (sel == 17) a = 32'(DEPTH);
        else if (sel == 18) a = 32'h0002_0000 + 32'($urandom_range(0, 255));
        else                a = $urandom;
        return mk(a, $urandom, $urandom_range(0, 4) < 2);
    endfunction

    task automatic check_outputs();
        logic [N-1:0] ev;
        logic [N-1:0] ee;
        bit em;
        if (rst_seen) begin
            check("reset_outputs", {rsp_valid, rsp_err, rsp_data, mem_en, mem_we, mem_addr, mem_din}, '0);
        end else begin
            ev = exp_rv.exists(cyc) ? exp_rv[cyc] : '0;
            ee = exp_re.exists(cyc) ? exp_re[cyc] : '0;
            check("rsp_valid", rsp_valid, ev);
            check("rsp_err", rsp_err, ee);
            if (ev != '0) check("rsp_data", rsp_data, exp_rd[cyc]);
            em = exp_mwe.exists(cyc);
            check("mem_en", mem_en, em);
            check("mem_we", mem_we, em ? exp_mwe[cyc] : 1'b0);
            if (em) check("mem_addr_din", {mem_addr, mem_din}, {exp_maddr[cyc], exp_mdin[cyc]});
        end
    endtask

    // One clock: drive inputs, check the combinational grant, predict, advance, check registered outputs.
    task automatic step(input logic rst_b, input logic [N-1:0] v);
        int g;
        logic [N-1:0] exp_ready;
        data_in r;
        bit err;
        rstn      = rst_b;
        req_valid = v;
        #1;
        g = rst_b ? model_grant(v, rr_m) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        if (!rst_b) begin
            for (int k = cyc + 1; k <= cyc + RDL + 2; k++) begin
                exp_rv.delete(k);
                exp_re.delete(k);
                exp_rd.delete(k);
                exp_mwe.delete(k);
                exp_maddr.delete(k);
                exp_mdin.delete(k);
            end
            rr_m     = 0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (g >= 0) begin
                r    = req[g];
                rr_m = (g + 1) % N;
                err  = (r.addr >= 32'(DEPTH));
                if (!err) begin
                    exp_mwe[cyc+1]   = r.we;
                    exp_maddr[cyc+1] = r.addr[AW-1:0];
                    exp_mdin[cyc+1]  = r.din;
                    if (r.we) model_mem[int'(r.addr)] = r.din;
                end
                if (!r.we) begin
                    exp_rv[cyc+RDL+2] = N'(1) << g;
                    exp_re[cyc+RDL+2] = err ? N'(1) << g : '0;
                    exp_rd[cyc+RDL+2] = err ? 32'h0 : model_read(int'(r.addr));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        last_grant = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rr_m        = 0;
        rst_seen    = 1'b1;
        last_grant  = -1;
        rstn        = 1'b0;
        req_valid   = '0;
        for (int p = 0; p < N; p++) req[p] = mk(32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        step(1'b0, '0);
        step(1'b0, '0);

        // Reset while a read is in flight: the response must never appear.
        req[2] = mk(32'd5, 32'h0, 1'b0);
        step(1'b1, 4'b0100);
        step(1'b0, '0);
        step(1'b0, '0);

        // All ports valid, each reading its own address: grants rotate from port 0.
        for (int p = 0; p < N; p++) req[p] = mk(32'(200 + p), 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1111);
        idle(4);

        // Write then read the same word from different ports.
        req[1] = mk(32'd100, 32'hDEADBEEF, 1'b1);
        step(1'b1, 4'b0010);
        req[3] = mk(32'd100, 32'h0, 1'b0);
        step(1'b1, 4'b1000);
        idle(4);

        // Out-of-range read returns an error; out-of-range write vanishes.
        req[0] = mk(32'd131072, 32'h0, 1'b0);
        step(1'b1, 4'b0001);
        req[0] = mk(32'h0002_0000, 32'h1234_5678, 1'b1);
        step(1'b1, 4'b0001);
        idle(4);

        // Pointer wrap, skipping idle ports, and a port dropping valid while waiting.
        req[2] = mk(32'd7, 32'h0, 1'b0);
        step(1'b1, 4'b0100);
        req[1] = mk(32'd1, 32'h0, 1'b0);
        req[3] = mk(32'd3, 32'h0, 1'b0);
        step(1'b1, 4'b1010);
        step(1'b1, 4'b0010);
        req[0] = mk(32'd0, 32'h0, 1'b0);
        step(1'b1, 4'b1101);
        step(1'b1, 4'b1000);
        idle(4);

        // Back-to-back write then read of the same address.
        req[0] = mk(32'd9, 32'd7, 1'b1);
        req[1] = mk(32'd9, 32'h0, 1'b0);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0010);
        idle(4);

        // Random traffic; an unserved request stays put until granted or withdrawn.
        cur_v      = '0;
        last_grant = -1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (cur_v[p] && last_grant != p) begin
                    if ($urandom_range(0, 9) == 0) cur_v[p] = 1'b0;
                end else begin
                    cur_v[p] = ($urandom_range(0, 9) < 6);
                    if (cur_v[p]) req[p] = rand_req();
                end
            end
            step(($urandom_range(0, 99) != 0), cur_v);
        end
        idle(RDL + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
